// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode sequencer driving the instruction unit strobes.
// Classifies the fetched instruction, waits for execute, then redirects or halts.
//
// state    | meaning
// IDLE     | waiting for stall to drop before starting a fetch
// FETCH    | memory read in flight, IM_LAT cycles
// LOAD     | capture memory data into IR, advance PC by 4
// DECODE   | IR classified and valid, waiting for ex_done
// REDIRECT | load PC from the mux selected on DECODE exit
// HALT     | break executed, left only by reset
module fetch_sequencer #(
  parameter int IM_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_out,
  input  logic             ex_done,
  input  logic             br_taken,
  input  logic             stall,
  output logic             PC_ld,
  output logic             PC_inc,
  output logic             IM_cs,
  output logic             IM_rd,
  output logic             IR_ld,
  output logic [1:0]       PC_sel,
  output logic             dec_valid,
  output logic [2:0]       dec_class,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    DECODE   = 3'd3,
    REDIRECT = 3'd4,
    HALT     = 3'd5
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(IM_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [2:0] cls;
  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_ir;

  assign op        = IR_out[31:26];
  assign funct     = IR_out[5:0];
  assign unused_ir = ^IR_out[25:6];

  always_comb begin
    cls = 3'd0;
    if (op == 6'b000000) begin
      if (funct == 6'b001000 || funct == 6'b001001) cls = 3'd3;
      else if (funct == 6'b001101)                  cls = 3'd4;
    end else if (op == 6'b000010 || op == 6'b000011) begin
      cls = 3'd2;
    end else if (op == 6'b000100 || op == 6'b000101) begin
      cls = 3'd1;
    end
  end

  // dec_valid is high exactly while in DECODE
  assign dec_class = dec_valid ? cls : 3'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= 4'd0;
      PC_ld     <= 1'b0;
      PC_inc    <= 1'b0;
      IM_cs     <= 1'b0;
      IM_rd     <= 1'b0;
      IR_ld     <= 1'b0;
      PC_sel    <= 2'b00;
      dec_valid <= 1'b0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      // outputs are registered for the state being entered
      PC_ld     <= 1'b0;
      PC_inc    <= 1'b0;
      IM_cs     <= 1'b0;
      IM_rd     <= 1'b0;
      IR_ld     <= 1'b0;
      dec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            state   <= FETCH;
            lat_cnt <= 4'd0;
            IM_cs   <= 1'b1;
            IM_rd   <= 1'b1;
          end
        end
        FETCH: begin
          IM_cs <= 1'b1;
          IM_rd <= 1'b1;
          if (lat_cnt == LAT_LAST) begin
            state  <= LOAD;
            IR_ld  <= 1'b1;
            PC_inc <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        LOAD: begin
          state     <= DECODE;
          fetch_cnt <= fetch_cnt + CNT_W'(1);
          dec_valid <= 1'b1;
        end
        DECODE: begin
          if (ex_done) begin
            case (cls)
              3'd4: begin
                state  <= HALT;
                halted <= 1'b1;
              end
              3'd2: begin
                state  <= REDIRECT;
                PC_sel <= 2'b01;
                PC_ld  <= 1'b1;
              end
              3'd3: begin
                state  <= REDIRECT;
                PC_sel <= 2'b11;
                PC_ld  <= 1'b1;
              end
              3'd1: begin
                if (br_taken) begin
                  state  <= REDIRECT;
                  PC_sel <= 2'b00;
                  PC_ld  <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end else begin
            dec_valid <= 1'b1;
          end
        end
        REDIRECT: state <= IDLE;
        HALT:     state <= HALT;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance with IM_LAT=1/CNT_W=32 and one
// with IM_LAT=3/CNT_W=4, each exercised while the other is held in reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_a = 1'b0;
  logic        reset_b = 1'b0;
  logic [31:0] IR_out = 32'h0;
  logic        ex_done = 1'b0;
  logic        br_taken = 1'b0;
  logic        stall = 1'b1;

  logic        PC_ld_a, PC_inc_a, IM_cs_a, IM_rd_a, IR_ld_a, dec_valid_a, halted_a;
  logic [1:0]  PC_sel_a;
  logic [2:0]  dec_class_a;
  logic [31:0] fetch_cnt_a;

  logic        PC_ld_b, PC_inc_b, IM_cs_b, IM_rd_b, IR_ld_b, dec_valid_b, halted_b;
  logic [1:0]  PC_sel_b;
  logic [2:0]  dec_class_b;
  logic [3:0]  fetch_cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] sel_model = 2'b00;

  always #5 clk = ~clk;

  fetch_sequencer #(.IM_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset_a), .IR_out(IR_out), .ex_done(ex_done),
    .br_taken(br_taken), .stall(stall), .PC_ld(PC_ld_a), .PC_inc(PC_inc_a),
    .IM_cs(IM_cs_a), .IM_rd(IM_rd_a), .IR_ld(IR_ld_a), .PC_sel(PC_sel_a),
    .dec_valid(dec_valid_a), .dec_class(dec_class_a), .halted(halted_a),
    .fetch_cnt(fetch_cnt_a)
  );

  fetch_sequencer #(.IM_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .IR_out(IR_out), .ex_done(ex_done),
    .br_taken(br_taken), .stall(stall), .PC_ld(PC_ld_b), .PC_inc(PC_inc_b),
    .IM_cs(IM_cs_b), .IM_rd(IM_rd_b), .IR_ld(IR_ld_b), .PC_sel(PC_sel_b),
    .dec_valid(dec_valid_b), .dec_class(dec_class_b), .halted(halted_b),
    .fetch_cnt(fetch_cnt_b)
  );

  // strobe vector {PC_ld, PC_inc, IM_cs, IM_rd, IR_ld}
  wire [4:0] stb_a = {PC_ld_a, PC_inc_a, IM_cs_a, IM_rd_a, IR_ld_a};
  wire [4:0] stb_b = {PC_ld_b, PC_inc_b, IM_cs_b, IM_rd_b, IR_ld_b};

  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_FETCH = 5'b00110;
  localparam logic [4:0] S_LOAD  = 5'b01111;
  localparam logic [4:0] S_PCLD  = 5'b10000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Starts sampled at a negedge in IDLE with stall=0; returns sampled in IDLE or HALT.
  task automatic run_instr(input logic [31:0] ir, input logic br, input logic [2:0] cls,
                           input logic redirect, input logic [1:0] sel_exp,
                           input logic halt_exp, input logic [31:0] cnt_exp);
    IR_out = ir; br_taken = br; ex_done = 1'b0;
    @(negedge clk); check("fetch_stb", 32'(stb_a), 32'(S_FETCH));
    @(negedge clk); check("load_stb", 32'(stb_a), 32'(S_LOAD));
    @(negedge clk);
    check("dec_valid", 32'(dec_valid_a), 32'd1);
    check("dec_stb", 32'(stb_a), 32'(S_NONE));
    check("dec_class", 32'(dec_class_a), 32'(cls));
    check("fetch_cnt", fetch_cnt_a, cnt_exp);
    @(negedge clk);
    check("dec_hold", 32'(dec_valid_a), 32'd1);
    check("sel_hold", 32'(PC_sel_a), 32'(sel_model));
    ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    check("exit_valid", 32'(dec_valid_a), 32'd0);
    if (halt_exp) begin
      check("halted", 32'(halted_a), 32'd1);
      check("halt_stb", 32'(stb_a), 32'(S_NONE));
    end else if (redirect) begin
      sel_model = sel_exp;
      check("redir_stb", 32'(stb_a), 32'(S_PCLD));
      check("redir_sel", 32'(PC_sel_a), 32'(sel_model));
      @(negedge clk);
      check("post_redir_stb", 32'(stb_a), 32'(S_NONE));
      check("post_redir_sel", 32'(PC_sel_a), 32'(sel_model));
    end else begin
      check("noredir_stb", 32'(stb_a), 32'(S_NONE));
      check("noredir_sel", 32'(PC_sel_a), 32'(sel_model));
    end
  endtask

  initial begin
    #1;
    check("rst_stb", 32'(stb_a), 32'(S_NONE));
    check("rst_sel", 32'(PC_sel_a), 32'd0);
    check("rst_cnt", fetch_cnt_a, 32'd0);
    check("rst_misc", {29'd0, dec_valid_a, halted_a, |dec_class_a}, 32'd0);

    @(negedge clk); reset_a = 1'b1; stall = 1'b0;
    run_instr(32'h2108_0001, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 32'd1);  // addi
    run_instr(32'h0800_0040, 1'b0, 3'd2, 1'b1, 2'b01, 1'b0, 32'd2);  // j
    run_instr(32'h1000_0003, 1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 32'd3);  // beq not taken
    run_instr(32'h1000_0003, 1'b1, 3'd1, 1'b1, 2'b00, 1'b0, 32'd4);  // beq taken
    run_instr(32'h03E0_0008, 1'b0, 3'd3, 1'b1, 2'b11, 1'b0, 32'd5);  // jr $ra
    run_instr(32'h0C00_0010, 1'b0, 3'd2, 1'b1, 2'b01, 1'b0, 32'd6);  // jal
    run_instr(32'h0060_F809, 1'b0, 3'd3, 1'b1, 2'b11, 1'b0, 32'd7);  // jalr
    run_instr(32'h1420_0002, 1'b1, 3'd1, 1'b1, 2'b00, 1'b0, 32'd8);  // bne taken
    run_instr(32'h0400_000D, 1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 32'd9);  // funct 001101, op!=0
    run_instr(32'h0000_000D, 1'b0, 3'd4, 1'b0, 2'b00, 1'b1, 32'd10); // break

    for (int i = 0; i < 20; i++) begin
      ex_done = i[0];
      @(negedge clk);
      check("halt_idle_stb", 32'(stb_a), 32'(S_NONE));
      check("halt_stay", 32'(halted_a), 32'd1);
    end
    ex_done = 1'b0;
    check("halt_cnt", fetch_cnt_a, 32'd10);

    // IM_LAT=3 instance
    reset_a = 1'b0; stall = 1'b1; IR_out = 32'h2108_0001;
    @(negedge clk); reset_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_idle", 32'(stb_b), 32'(S_NONE));
    end
    stall = 1'b0;
    @(negedge clk); check("b_fetch1", 32'(stb_b), 32'(S_FETCH));
    stall = 1'b1;
    @(negedge clk); check("b_fetch2", 32'(stb_b), 32'(S_FETCH));
    @(negedge clk); check("b_fetch3", 32'(stb_b), 32'(S_FETCH));
    @(negedge clk); check("b_load", 32'(stb_b), 32'(S_LOAD));
    @(negedge clk);
    check("b_dec", 32'(dec_valid_b), 32'd1);
    check("b_cnt1", 32'(fetch_cnt_b), 32'd1);
    ex_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b_stall_idle", 32'(stb_b), 32'(S_NONE));
    check("b_stall_valid", 32'(dec_valid_b), 32'd0);

    stall = 1'b0;
    @(negedge clk);
    check("b_fetch_again", 32'(stb_b), 32'(S_FETCH));
    #2 reset_b = 1'b0;
    #1;
    check("async_stb", 32'(stb_b), 32'(S_NONE));
    check("async_cnt", 32'(fetch_cnt_b), 32'd0);
    check("async_misc", {29'd0, dec_valid_b, halted_b, |PC_sel_b}, 32'd0);

    @(negedge clk); reset_b = 1'b1;
    repeat (96) @(negedge clk);
    check("wrap16_cnt", 32'(fetch_cnt_b), 32'd0);
    check("wrap16_idle", 32'(stb_b), 32'(S_NONE));
    repeat (6) @(negedge clk);
    check("wrap17_cnt", 32'(fetch_cnt_b), 32'd1);
    ex_done = 1'b0; stall = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
